// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the time-multiplexed FIR controller:
//   - fir_state_e      : controller state encoding (IDLE / MAC / OUT)
//   - FIR_DEFAULT_COEF : 16-tap reset coefficient table (Q15 low-pass)
//   - clog2            : elaboration-time ceiling log2 for address widths
// No ports (package).
// -----------------------------------------------------------------------------
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } fir_state_e;

    localparam int FIR_DEFAULT_TAPS = 16;

    localparam logic [15:0] FIR_DEFAULT_COEF [0:15] = '{
        16'hFDDD, 16'hFFF6, 16'h02EB, 16'h0671,
        16'h0A1B, 16'h0D6E, 16'h0FF5, 16'h1152,
        16'h1152, 16'h0FF5, 16'h0D6E, 16'h0A1B,
        16'h0671, 16'h02EB, 16'hFFF6, 16'hFDDD
    };

    // Ceiling log2, never below 1 so a single-tap build still has a 1-bit index.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// -----------------------------------------------------------------------------
// fir_mac_unit
// Registered signed multiply-accumulate.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset, clears the accumulator
//   clr_i  : synchronous clear (has priority over en_i)
//   en_i   : accumulate a_i * b_i this cycle
//   a_i    : signed IN_W operand
//   b_i    : signed IN_W operand
//   res_o  : low OUT_W bits of the ACC_W-bit accumulator
// -----------------------------------------------------------------------------
module fir_mac_unit #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 36,
    parameter int OUT_W = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [IN_W-1:0]  a_i,
    input  logic signed [IN_W-1:0]  b_i,
    output logic [OUT_W-1:0]        res_o
);

    logic signed [2*IN_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;

    // Operands are sign-extended to full product width before multiplying.
    assign prod = (2*IN_W)'(a_i) * (2*IN_W)'(b_i);

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Modular truncation: guard bits only prevent overflow inside the sum.
    assign res_o = acc_q[OUT_W-1:0];

endmodule

// File: rtl/fir_mac_sched.sv
// -----------------------------------------------------------------------------
// fir_mac_sched
// Time-multiplexed FIR: one shared MAC is stepped TAPS times per input sample
// over a circular sample history and a writable coefficient table.
//   clk, rst_n            : clock (rising edge), async active-low reset
//   in_valid/in_ready     : sample handshake, in_data = x[n] (signed WIDTH)
//   out_valid/out_ready   : result handshake, out_data = y[n] (low 2*WIDTH bits)
//   coef_we/addr/wdata    : coefficient write port, honoured only in IDLE
//   busy                  : high while in MAC or OUT
//   dbg_state_o           : current controller state
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE. out_valid is high only in OUT and
// out_data is held constant until the edge where out_ready is seen.
// -----------------------------------------------------------------------------
module fir_mac_sched
    import fir_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAPS  = 16,
    parameter int AW    = clog2(TAPS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_data,
    input  logic                 coef_we,
    input  logic [AW-1:0]        coef_addr,
    input  logic [WIDTH-1:0]     coef_wdata,
    output logic                 busy,
    output fir_state_e           dbg_state_o
);

    localparam int            ACC_W    = 2*WIDTH + AW;
    localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);
    localparam logic [AW:0]   TAPS_W   = (AW+1)'(TAPS);

    fir_state_e state_q, state_d;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] hist_q [TAPS];
    logic [WIDTH-1:0] coef_q [TAPS];

    logic             accept;
    logic             coef_wr;
    logic             mac_clr;
    logic             mac_en;
    logic [AW-1:0]    wr_ptr_inc;
    logic [AW-1:0]    hist_idx;
    logic [2*WIDTH-1:0] mac_res;

    function automatic logic [WIDTH-1:0] coef_init(input int idx);
        logic signed [31:0] wide;
        wide = '0;
        if (TAPS == FIR_DEFAULT_TAPS) begin
            wide = 32'(signed'(FIR_DEFAULT_COEF[idx[3:0]]));
        end
        return WIDTH'(wide);
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)          state_d = ST_MAC;
            ST_MAC:  if (k_q == LAST_IDX)   state_d = ST_OUT;
            ST_OUT:  if (out_ready)         state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                mac_clr  = in_valid;
            end
            ST_MAC: begin
                busy   = 1'b1;
                mac_en = 1'b1;
            end
            ST_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign dbg_state_o = state_q;

    // ---------------- pointers and indices ----------------
    assign accept     = in_valid && in_ready;
    assign wr_ptr_inc = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + AW'(1);

    // The sample is written at wr_ptr+1 and wr_ptr then moves onto it, so
    // during MAC wr_ptr_q points at x[n] and x[n-k] sits k slots behind it.
    always_comb begin
        if (k_q > wr_ptr_q) begin
            hist_idx = AW'({1'b0, wr_ptr_q} + TAPS_W - {1'b0, k_q});
        end else begin
            hist_idx = wr_ptr_q - k_q;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        k_d      = k_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_inc;
            k_d      = '0;
        end else if (state_q == ST_MAC) begin
            k_d = (k_q == LAST_IDX) ? '0 : k_q + AW'(1);
        end
    end

    // An IDLE write lands at the same edge as a sample accept, so the first
    // MAC cycle of that sample already reads the new coefficient.
    assign coef_wr = coef_we && (state_q == ST_IDLE) && ({1'b0, coef_addr} < TAPS_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            k_q      <= '0;
            for (int i = 0; i < TAPS; i++) begin
                hist_q[i] <= '0;
                coef_q[i] <= coef_init(i);
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            k_q      <= k_d;
            if (accept) begin
                hist_q[wr_ptr_inc] <= in_data;
            end
            if (coef_wr) begin
                coef_q[coef_addr] <= coef_wdata;
            end
        end
    end

    // ---------------- shared MAC ----------------
    fir_mac_unit #(
        .IN_W  (WIDTH),
        .ACC_W (ACC_W),
        .OUT_W (2*WIDTH)
    ) u_mac (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (mac_clr),
        .en_i   (mac_en),
        .a_i    (coef_q[k_q]),
        .b_i    (hist_q[hist_idx]),
        .res_o  (mac_res)
    );

    // Zero outside OUT so a stale accumulator is never visible.
    assign out_data = out_valid ? mac_res : '0;

endmodule

// File: tb/tb_fir_mac_sched.sv
module tb_fir_mac_sched;
    import fir_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        in_valid   = 1'b0;
    logic        in_ready;
    logic [15:0] in_data    = '0;
    logic        out_valid;
    logic        out_ready  = 1'b0;
    logic [31:0] out_data;
    logic        coef_we    = 1'b0;
    logic [3:0]  coef_addr  = '0;
    logic [15:0] coef_wdata = '0;
    logic        busy;
    fir_state_e  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    // Default-coefficient impulse response, sign-extended to 32 bits.
    logic [31:0] imp_tab [16] = '{
        32'hFFFFFDDD, 32'hFFFFFFF6, 32'h000002EB, 32'h00000671,
        32'h00000A1B, 32'h00000D6E, 32'h00000FF5, 32'h00001152,
        32'h00001152, 32'h00000FF5, 32'h00000D6E, 32'h00000A1B,
        32'h00000671, 32'h000002EB, 32'hFFFFFFF6, 32'hFFFFFDDD
    };

    always #5 clk = ~clk;

    fir_mac_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_wdata  (coef_wdata),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        coef_we    = 1'b0;
        in_data    = '0;
        coef_addr  = '0;
        coef_wdata = '0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic write_coef(input logic [3:0] addr, input logic [15:0] data);
        coef_we    = 1'b1;
        coef_addr  = addr;
        coef_wdata = data;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // Sends one sample with out_ready held high; lat counts cycles from the
    // accept cycle to the first cycle with out_valid high.
    task automatic run_sample(input logic [15:0] x, input bit with_we, input logic [15:0] we_data,
                              output logic [31:0] got, output int lat, output bit to);
        int n;
        got = '0;
        lat = 0;
        to  = 1'b0;
        n   = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            to = 1'b1;
            return;
        end
        in_valid  = 1'b1;
        in_data   = x;
        out_ready = 1'b1;
        if (with_we) begin
            coef_we    = 1'b1;
            coef_addr  = 4'd0;
            coef_wdata = we_data;
        end
        @(negedge clk);
        in_valid = 1'b0;
        coef_we  = 1'b0;
        lat      = 1;
        while (out_valid !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (out_valid !== 1'b1) begin
            to = 1'b1;
            return;
        end
        got = out_data;
        @(negedge clk);
    endtask

    task automatic wait_result(output logic [31:0] got, output bit to);
        int n;
        got = '0;
        to  = 1'b0;
        n   = 0;
        out_ready = 1'b1;
        while (out_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (out_valid !== 1'b1) begin
            to = 1'b1;
            return;
        end
        got = out_data;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 32'h0)  begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_impulse();
        logic [31:0] got, exp;
        int lat;
        bit to;
        do_reset();
        for (int i = 0; i < 16; i++) exp_q.push_back(imp_tab[i]);
        for (int i = 0; i < 16; i++) begin
            run_sample((i == 0) ? 16'd1 : 16'd0, 1'b0, 16'd0, got, lat, to);
            exp = exp_q.pop_front();
            n_checks++;
            if (to || got !== exp) begin n_fail++; $display("FAIL impulse_y[%0d]: got %h (timeout %0d) expected %h", i, got, to, exp); end
            n_checks++;
            if (lat != 17) begin n_fail++; $display("FAIL impulse_latency[%0d]: got %0d expected 17", i, lat); end
        end
    endtask

    task automatic test_step();
        logic [31:0] got, exp;
        int lat;
        bit to;
        do_reset();
        for (int k = 0; k < 16; k++) write_coef(4'(k), 16'd1);
        for (int n = 1; n <= 20; n++) exp_q.push_back(32'(100 * ((n < 16) ? n : 16)));
        for (int n = 1; n <= 20; n++) begin
            run_sample(16'd100, 1'b0, 16'd0, got, lat, to);
            exp = exp_q.pop_front();
            n_checks++;
            if (to || got !== exp) begin n_fail++; $display("FAIL step_y[%0d]: got %0d (timeout %0d) expected %0d", n, got, to, exp); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] got, exp;
        int lat;
        bit to;
        do_reset();
        for (int k = 0; k < 16; k++) write_coef(4'(k), 16'h7FFF);
        // 0x7FFF * 0x7FFF = 0x3FFF0001; output n carries n such products.
        for (int n = 1; n <= 16; n++) exp_q.push_back(32'(64'(n) * 64'h3FFF0001));
        for (int n = 1; n <= 16; n++) begin
            run_sample(16'h7FFF, 1'b0, 16'd0, got, lat, to);
            exp = exp_q.pop_front();
            n_checks++;
            if (to || got !== exp) begin n_fail++; $display("FAIL overflow_y[%0d]: got %h (timeout %0d) expected %h", n, got, to, exp); end
        end
        n_checks++;
        if (got !== 32'hFFF00010) begin n_fail++; $display("FAIL overflow_last: got %h expected fff00010", got); end
    endtask

    task automatic test_backpressure();
        logic [31:0] got, hold;
        int lat, n;
        bit to;
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'd1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_reach_out: got out_valid %b expected 1", out_valid); end
        hold = out_data;
        n_checks++;
        if (hold !== 32'hFFFFFDDD) begin n_fail++; $display("FAIL bp_data: got %h expected fffffddd", hold); end
        for (int c = 0; c < 5; c++) begin
            in_valid = (c % 2 == 0);
            in_data  = 16'h0055;
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1)   begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, out_valid); end
            n_checks++; if (out_data !== 32'hFFFFFDDD) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h expected fffffddd", c, out_data); end
            n_checks++; if (in_ready !== 1'b0)    begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, in_ready); end
            n_checks++; if (busy !== 1'b1)        begin n_fail++; $display("FAIL bp_busy[%0d]: got %b expected 1", c, busy); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        // If 0x55 had slipped in, it would appear in this result.
        run_sample(16'd0, 1'b0, 16'd0, got, lat, to);
        n_checks++;
        if (to || got !== 32'hFFFFFFF6) begin n_fail++; $display("FAIL bp_next_y: got %h (timeout %0d) expected fffffff6", got, to); end
    endtask

    task automatic test_coef_busy_write();
        logic [31:0] got;
        int lat;
        bit to;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'd1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        write_coef(4'd0, 16'd2);
        wait_result(got, to);
        n_checks++;
        if (to || got !== 32'hFFFFFDDD) begin n_fail++; $display("FAIL coef_busy_dropped: got %h (timeout %0d) expected fffffddd", got, to); end
        do_reset();
        run_sample(16'd1, 1'b1, 16'd2, got, lat, to);
        n_checks++;
        if (to || got !== 32'h00000002) begin n_fail++; $display("FAIL coef_idle_write: got %h (timeout %0d) expected 00000002", got, to); end
        n_checks++;
        if (lat != 17) begin n_fail++; $display("FAIL coef_idle_latency: got %0d expected 17", lat); end
    endtask

    task automatic test_reset_mid_mac();
        logic [31:0] got;
        int lat, seen;
        bit to;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'd1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (dbg_state !== ST_MAC) begin n_fail++; $display("FAIL rst_mid_state: got %0d expected %0d", dbg_state, ST_MAC); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL rst_mid_no_output: got %0d valid cycles expected 0", seen); end
        exp_q.push_back(32'hFFFFFDDD);
        exp_q.push_back(32'hFFFFFFF6);
        exp_q.push_back(32'h000002EB);
        for (int i = 0; i < 3; i++) begin
            logic [31:0] exp;
            run_sample((i == 0) ? 16'd1 : 16'd0, 1'b0, 16'd0, got, lat, to);
            exp = exp_q.pop_front();
            n_checks++;
            if (to || got !== exp) begin n_fail++; $display("FAIL rst_mid_y[%0d]: got %h (timeout %0d) expected %h", i, got, to, exp); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        @(negedge clk);
        test_reset();
        test_impulse();
        test_step();
        test_backpressure();
        test_coef_busy_write();
        test_overflow();
        test_reset_mid_mac();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
